warp_issue_arbiter: RTL

//  Round-robin arbiter that shares one decoder/ALU/PC datapath between NUM_WARPS warps.

---
 rtl/warp_issue_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/warp_issue_arbiter.sv
// warp_issue_arbiter
//   Round-robin owner arbiter for the datapath shared by all warps (decoder,
//   ALU and PC logic). A warp requests the datapath once its instruction has
//   been fetched. It keeps ownership until its writeback/update completes, it
//   finishes the kernel, or it is deactivated. Ownership then passes to the
//   next eligible warp with no idle cycle in between.
//   The block also reports a kernel-level done and a sticky flag that is set
//   when one owner holds the datapath for too long.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   warp_active   per-warp: started and eligible for arbitration
//   warp_req      per-warp: level request for the shared datapath
//   warp_release  per-warp: single-cycle pulse at the end of the update stage
//   warp_done     per-warp: level, the warp has executed RET
//   grant         one-hot owner of the datapath, all-zero when idle
//   grant_valid   OR of grant
//   warp_select   binary index of the current or most recent owner
//   all_done      registered: at least one warp active and every active warp done
//   hold_timeout  sticky: one grant was held for MAX_HOLD_CYCLES cycles
module warp_issue_arbiter #(
  parameter int NUM_WARPS       = 2,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WARPS-1:0]         warp_active,
  input  logic [NUM_WARPS-1:0]         warp_req,
  input  logic [NUM_WARPS-1:0]         warp_release,
  input  logic [NUM_WARPS-1:0]         warp_done,
  output logic [NUM_WARPS-1:0]         grant,
  output logic                         grant_valid,
  output logic [$clog2(NUM_WARPS)-1:0] warp_select,
  output logic                         all_done,
  output logic                         hold_timeout
);

  localparam int SEL_W = $clog2(NUM_WARPS);
  localparam int CNT_W = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_WARPS - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD_CYCLES);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t               state_q, state_d;
  logic [NUM_WARPS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 all_done_q, all_done_d;

  logic [NUM_WARPS-1:0] elig;
  logic                 owner_end;
  logic [SEL_W-1:0]     scan_base;
  logic [SEL_W-1:0]     scan_idx;
  logic [SEL_W-1:0]     win_idx;
  logic                 win_found;
  logic [NUM_WARPS-1:0] win_onehot;
  logic [CNT_W-1:0]     hold_inc;

  assign elig = warp_active & ~warp_done & warp_req;

  // A deactivated owner ends its grant just as a release or done would.
  assign owner_end = |(grant_q & (warp_release | warp_done | ~warp_active));

  // When ownership is handed over, the scan starts just after the owner that is
  // leaving. The owner is checked last, so it wins again only if no other warp
  // is eligible.
  assign scan_base = (state_q == OWNED) ? sel_q : rr_ptr_q;

  // The wrap compares against the last index explicitly, so the scan stays in
  // range when NUM_WARPS is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = scan_base;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      if (!win_found && elig[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_onehot = NUM_WARPS'(1) << win_idx;
  assign hold_inc   = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = timeout_q;
    all_done_d = (|warp_active) & (&(~warp_active | warp_done));

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = win_onehot;
          sel_d      = win_idx;
          hold_cnt_d = '0;
          state_d    = OWNED;
        end
      end
      OWNED: begin
        if (owner_end) begin
          rr_ptr_d = sel_q;
          if (win_found) begin
            grant_d    = win_onehot;
            sel_d      = win_idx;
            hold_cnt_d = '0;
          end else begin
            grant_d    = '0;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end
        end else begin
          // The timeout only raises a flag. The owner keeps its grant.
          hold_cnt_d = hold_inc;
          if (hold_inc == HOLD_MAX) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= LAST_IDX;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
      all_done_q <= all_done_d;
    end
  end

  assign grant        = grant_q;
  assign grant_valid  = |grant_q;
  assign warp_select  = sel_q;
  assign all_done     = all_done_q;
  assign hold_timeout = timeout_q;

endmodule
